// File: rtl/regs_pkg.sv
// regs shared types and constants.
// Address/word widths, x0 constants and the latched debug request bundle.
package regs_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = 5'd0;
  localparam logic [31:0]           ZERO_WORD = 32'h0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } dbg_req_t;

endpackage

// File: rtl/regs_dbg_if.sv
// Debug access port bundle: four-phase req/ack with read data.
// master = debugger side, slave = register file side.
interface regs_dbg_if;
  import regs_pkg::*;

  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [REG_ADDR_W-1:0] dbg_addr_i;
  logic [31:0]           dbg_wdata_i;
  logic                  dbg_ack_o;
  logic [31:0]           dbg_rdata_o;

  modport master (
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_ack_o, dbg_rdata_o
  );

  modport slave (
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_ack_o, dbg_rdata_o
  );

endinterface

// File: rtl/regs_dbg_ctrl.sv
// Debug access controller: IDLE/PEND/ACK FSM, starvation counter, stall_o.
// Ports: core_wen_i, dbg req/we/addr/wdata in; ack, stall, write strobe, read capture out.
module regs_dbg_ctrl
  import regs_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_wen_i,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]           dbg_wdata_i,
  output logic                  dbg_ack_o,
  output logic                  stall_o,
  output logic                  wr_en_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic                  rd_cap_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  dbg_req_t   req_q, req_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stall_q, stall_d;
  logic       commit;

  // Debug only gets the write port when the core is not using it.
  assign commit = (state_q == S_PEND) && !core_wen_i;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (dbg_req_i) begin
          req_d   = '{we: dbg_we_i,
                      addr: dbg_addr_i,
                      wdata: dbg_wdata_i};
          state_d = S_PEND;
        end
      end
      (state_q == S_PEND): begin
        if (!core_wen_i) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
          stall_d = 1'b0;
        end else begin
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
          if (32'(cnt_d) >= STARVE_LIMIT)
            stall_d = 1'b1;
        end
      end
      (state_q == S_ACK): begin
        if (!dbg_req_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign dbg_ack_o = (state_q == S_ACK);
  assign stall_o   = stall_q;
  assign wr_en_o   = commit && req_q.we;
  assign wr_addr_o = req_q.addr;
  assign wr_data_o = req_q.wdata;
  assign rd_cap_o  = commit && !req_q.we;
  assign rd_addr_o = req_q.addr;

endmodule

// File: rtl/regs.sv
// RV32I 32x32 register file, x0 hardwired, same-cycle write-to-read bypass.
// Ports: rs1/rs2 read, core write-back, debug slave port, stall_o. Option: REGS_DEBUG_PORT_EN.
module regs
  import regs_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [31:0]           rs1_data_o,
  output logic [31:0]           rs2_data_o,
  input  logic                  reg_wen_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic [31:0]           reg_wdata_i,
  regs_dbg_if.slave             dbg,
  output logic                  stall_o
);

  logic [31:0]           rf_q [REG_NUM-1:1];
  logic                  d_wr_en;
  logic [REG_ADDR_W-1:0] d_wr_addr;
  logic [31:0]           d_wr_data;
  logic                  we_en;
  logic [REG_ADDR_W-1:0] waddr;
  logic [31:0]           wdata;

`ifdef REGS_DEBUG_PORT_EN
  logic                  rd_cap;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [31:0]           dbg_rdata_q;

  regs_dbg_ctrl #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_dbg_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_wen_i (reg_wen_i),
    .dbg_req_i  (dbg.dbg_req_i),
    .dbg_we_i   (dbg.dbg_we_i),
    .dbg_addr_i (dbg.dbg_addr_i),
    .dbg_wdata_i(dbg.dbg_wdata_i),
    .dbg_ack_o  (dbg.dbg_ack_o),
    .stall_o    (stall_o),
    .wr_en_o    (d_wr_en),
    .wr_addr_o  (d_wr_addr),
    .wr_data_o  (d_wr_data),
    .rd_cap_o   (rd_cap),
    .rd_addr_o  (rd_addr)
  );

  // Captures the array before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbg_rdata_q <= ZERO_WORD;
    else if (rd_cap)
      dbg_rdata_q <= (rd_addr == ZERO_REG)
                   ? ZERO_WORD : rf_q[rd_addr];
  end

  assign dbg.dbg_rdata_o = dbg_rdata_q;
`else
  localparam int unsigned unused_limit = STARVE_LIMIT;
  logic unused_dbg;

  assign unused_dbg = ^{dbg.dbg_req_i, dbg.dbg_we_i,
                        dbg.dbg_addr_i, dbg.dbg_wdata_i};
  assign d_wr_en         = 1'b0;
  assign d_wr_addr       = ZERO_REG;
  assign d_wr_data       = ZERO_WORD;
  assign dbg.dbg_ack_o   = 1'b0;
  assign dbg.dbg_rdata_o = ZERO_WORD;
  assign stall_o         = 1'b0;
`endif

  // Core write-back has priority over the debug write.
  assign we_en = reg_wen_i | d_wr_en;
  assign waddr = reg_wen_i ? reg_waddr_i : d_wr_addr;
  assign wdata = reg_wen_i ? reg_wdata_i : d_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_NUM; i++)
        rf_q[i] <= ZERO_WORD;
    end else if (we_en && waddr != ZERO_REG) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign rs1_data_o =
    (rs1_addr_i == ZERO_REG)        ? ZERO_WORD :
    (we_en && waddr == rs1_addr_i)  ? wdata     :
                                      rf_q[rs1_addr_i];

  assign rs2_data_o =
    (rs2_addr_i == ZERO_REG)        ? ZERO_WORD :
    (we_en && waddr == rs2_addr_i)  ? wdata     :
                                      rf_q[rs2_addr_i];

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: transaction-level model plus directed literals.
// Follows REGS_DEBUG_PORT_EN to select debug expectations.
module tb_regs;
  import regs_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        stall;

  regs_dbg_if dbg();

  regs #(.STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .reg_wen_i  (reg_wen),
    .reg_waddr_i(reg_waddr),
    .reg_wdata_i(reg_wdata),
    .dbg        (dbg.slave),
    .stall_o    (stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: architectural registers plus one outstanding debug transaction.
  logic [31:0] m_rf [32];
  bit          m_pend, m_ack;
  int          m_wait;
  logic [31:0] m_rdata;
  bit          l_we;
  logic [4:0]  l_addr;
  logic [31:0] l_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_rf[i]) m_rf[i] <= 32'h0;
      m_pend  <= 1'b0;
      m_ack   <= 1'b0;
      m_wait  <= 0;
      m_rdata <= 32'h0;
    end else begin
      if (m_pend) begin
        if (!reg_wen) begin
          if (l_we) begin
            if (l_addr != 5'd0) m_rf[l_addr] <= l_wdata;
          end else begin
            m_rdata <= m_rf[l_addr];
          end
          m_pend <= 1'b0;
          m_ack  <= 1'b1;
          m_wait <= 0;
        end else if (m_wait < 15) begin
          m_wait <= m_wait + 1;
        end
      end else if (m_ack) begin
        if (!dbg.dbg_req_i) m_ack <= 1'b0;
      end else if (dbg.dbg_req_i) begin
`ifdef REGS_DEBUG_PORT_EN
        l_we    <= dbg.dbg_we_i;
        l_addr  <= dbg.dbg_addr_i;
        l_wdata <= dbg.dbg_wdata_i;
        m_pend  <= 1'b1;
`endif
      end
      if (reg_wen && reg_waddr != 5'd0)
        m_rf[reg_waddr] <= reg_wdata;
    end
  end

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    we = reg_wen;
    wa = reg_waddr;
    wd = reg_wdata;
    if (!reg_wen && m_pend && l_we) begin
      we = 1'b1;
      wa = l_addr;
      wd = l_wdata;
    end
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit st;
    if (!rst_n) return;
    st = m_pend && (m_wait >= LIMIT);
    chk("rs1", rs1_data, exp_rd(rs1_addr));
    chk("rs2", rs2_data, exp_rd(rs2_addr));
    chk("ack", {31'b0, dbg.dbg_ack_o}, {31'b0, m_ack});
    chk("stall", {31'b0, stall}, {31'b0, st});
    chk("rdata", dbg.dbg_rdata_o, m_rdata);
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rs1_addr = 0; rs2_addr = 0;
    reg_wen = 0; reg_waddr = 0; reg_wdata = 0;
    dbg.dbg_req_i = 0; dbg.dbg_we_i = 0;
    dbg.dbg_addr_i = 0; dbg.dbg_wdata_i = 0;
    #3;
    chk("rst_ack", {31'b0, dbg.dbg_ack_o}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rdata", dbg.dbg_rdata_o, 32'h0);
    adv(); adv();
    rst_n = 1'b1;

    // All registers zero after reset.
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      sample();
      chk("rst_rs1", rs1_data, 32'h0);
      chk("rst_rs2", rs2_data, 32'h0);
      adv();
    end

    // x0 write dropped.
    reg_wen = 1; reg_waddr = 0; reg_wdata = 32'hDEADBEEF;
    rs1_addr = 0; rs2_addr = 0;
    sample();
    chk("x0_byp", rs1_data, 32'h0);
    adv();
    reg_wen = 0;
    sample();
    chk("x0_rs1", rs1_data, 32'h0);
    chk("x0_rs2", rs2_data, 32'h0);
    adv();

    // Bypass then array.
    reg_wen = 1; reg_waddr = 5; reg_wdata = 32'h12345678;
    rs1_addr = 5; rs2_addr = 0;
    sample();
    chk("byp_x5", rs1_data, 32'h12345678);
    adv();
    reg_wen = 0; rs2_addr = 5;
    sample();
    chk("arr_x5_1", rs1_data, 32'h12345678);
    chk("arr_x5_2", rs2_data, 32'h12345678);
    adv();

    // Debug write x7; later input changes ignored.
    dbg.dbg_req_i = 1; dbg.dbg_we_i = 1;
    dbg.dbg_addr_i = 7; dbg.dbg_wdata_i = 32'hA5A5A5A5;
    rs1_addr = 7; rs2_addr = 8;
    sample();
    chk("dw_ack0", {31'b0, dbg.dbg_ack_o}, 32'h0);
    adv();
    dbg.dbg_addr_i = 8; dbg.dbg_wdata_i = 32'h0BAD0BAD;
    sample();
`ifdef REGS_DEBUG_PORT_EN
    chk("dw_byp", rs1_data, 32'hA5A5A5A5);
`endif
    chk("dw_ack1", {31'b0, dbg.dbg_ack_o}, 32'h0);
    adv();
    sample();
`ifdef REGS_DEBUG_PORT_EN
    chk("dw_ack2", {31'b0, dbg.dbg_ack_o}, 32'h1);
    chk("dw_x7", rs1_data, 32'hA5A5A5A5);
`else
    chk("dw_ack2", {31'b0, dbg.dbg_ack_o}, 32'h0);
    chk("dw_x7", rs1_data, 32'h0);
`endif
    chk("dw_x8", rs2_data, 32'h0);
    adv();
    dbg.dbg_req_i = 0;
    cyc();
    sample();
    chk("dw_ackdrop", {31'b0, dbg.dbg_ack_o}, 32'h0);
    adv();

    // Debug read x5 starved by core write-back.
    reg_wen = 1; reg_waddr = 9; reg_wdata = 32'h1;
    dbg.dbg_req_i = 1; dbg.dbg_we_i = 0; dbg.dbg_addr_i = 5;
    rs1_addr = 9; rs2_addr = 5;
    cyc();
    for (int k = 0; k < LIMIT; k++) begin
      sample();
      chk("starve_st0", {31'b0, stall}, 32'h0);
      adv();
    end
    reg_wen = 0;
    sample();
`ifdef REGS_DEBUG_PORT_EN
    chk("starve_st1", {31'b0, stall}, 32'h1);
`else
    chk("starve_st1", {31'b0, stall}, 32'h0);
`endif
    chk("starve_ack0", {31'b0, dbg.dbg_ack_o}, 32'h0);
    adv();
    sample();
`ifdef REGS_DEBUG_PORT_EN
    chk("dr_ack", {31'b0, dbg.dbg_ack_o}, 32'h1);
    chk("dr_rdata", dbg.dbg_rdata_o, 32'h12345678);
`else
    chk("dr_ack", {31'b0, dbg.dbg_ack_o}, 32'h0);
    chk("dr_rdata", dbg.dbg_rdata_o, 32'h0);
`endif
    chk("dr_stall", {31'b0, stall}, 32'h0);
    adv();
    dbg.dbg_req_i = 0;
    cyc(); cyc();

`ifndef REGS_DEBUG_PORT_EN
    // Disabled port: debug writes have no effect.
    dbg.dbg_we_i = 1; dbg.dbg_addr_i = 5;
    dbg.dbg_wdata_i = 32'hFFFF0000;
    rs1_addr = 5;
    for (int k = 0; k < 6; k++) begin
      dbg.dbg_req_i = k[0];
      sample();
      chk("off_ack", {31'b0, dbg.dbg_ack_o}, 32'h0);
      chk("off_stall", {31'b0, stall}, 32'h0);
      chk("off_x5", rs1_data, 32'h12345678);
      adv();
    end
    dbg.dbg_req_i = 0;
`endif

    // Core write sweep with neighbour reads.
    for (int i = 1; i < 32; i++) begin
      reg_wen = 1; reg_waddr = 5'(i);
      reg_wdata = 32'(i) * 32'h01010101;
      rs1_addr = 5'(i); rs2_addr = 5'(i - 1);
      cyc();
    end
    reg_wen = 0;
    rs1_addr = 3;
    sample();
    chk("sweep_x3", rs1_data, 32'h03030303);
    adv();

    // Reset while a starved debug write is pending.
    reg_wen = 1; reg_waddr = 9; reg_wdata = 32'h2;
    dbg.dbg_req_i = 1; dbg.dbg_we_i = 1;
    dbg.dbg_addr_i = 11; dbg.dbg_wdata_i = 32'hCAFEF00D;
    rs1_addr = 11; rs2_addr = 5;
    cyc();
    repeat (LIMIT) cyc();
    sample();
`ifdef REGS_DEBUG_PORT_EN
    chk("pre_rst_st", {31'b0, stall}, 32'h1);
`endif
    adv();
    rst_n = 0;
    #1;
    chk("mid_rst_st", {31'b0, stall}, 32'h0);
    chk("mid_rst_ack", {31'b0, dbg.dbg_ack_o}, 32'h0);
    chk("mid_rst_x11", rs1_data, 32'h0);
    chk("mid_rst_x5", rs2_data, 32'h0);
    dbg.dbg_req_i = 0; reg_wen = 0;
    adv();
    rst_n = 1;
    repeat (4) cyc();
    sample();
    chk("post_rst_x11", rs1_data, 32'h0);
    chk("post_rst_ack", {31'b0, dbg.dbg_ack_o}, 32'h0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regs.md
Name: regs

Overview:
- 32x32 integer register file for the RV32I core; the responder to the decode stage's rs1/rs2 read requests.
- Accepts the write-back from the execute stage.
- Provides same-cycle write-to-read bypass and hardwires x0 to zero.
- Adds a debug access port with a four-phase req/ack handshake. Debug accesses arbitrate against core write-back; a starvation counter can stall the pipeline.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a pending debug access may lose to core write-back before stall_o is raised (range 1..15)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
rs1_addr_i  input  5  read port 1 address, from decode
rs2_addr_i  input  5  read port 2 address, from decode
rs1_data_o  output  32  read port 1 data, combinational
rs2_data_o  output  32  read port 2 data, combinational
reg_wen_i  input  1  core write-back enable, from execute
reg_waddr_i  input  5  core write-back address
reg_wdata_i  input  32  core write-back data
dbg_req_i  input  1  debug request, four-phase
dbg_we_i  input  1  debug access is a write (1) or a read (0)
dbg_addr_i  input  5  debug register address
dbg_wdata_i  input  32  debug write data
dbg_ack_o  output  1  debug acknowledge
dbg_rdata_o  output  32  debug read data, valid while dbg_ack_o=1
stall_o  output  1  pipeline hold request to ctrl

Behaviour:
- Reset (rst_n low, async):
  - x1..x31 cleared to 0.
  - Debug FSM goes to IDLE; wait counter cleared.
  - dbg_ack_o=0, dbg_rdata_o=0, stall_o=0.
- Write-port selection: the effective write is the core write if reg_wen_i=1. Otherwise it is the debug write when the FSM commits a write in PEND. Otherwise there is no write.
- Array update: on posedge clk when the effective write is active and its address != 0. Writes to x0 are silently dropped.
- Reads (combinational, each port independently):
  - addr==0 -> 0.
  - Else if the effective write is active and its address equals the read address -> the effective write data (bypass).
  - Else -> the array contents.
  - rs1 and rs2 reading the same register return identical values.
- Debug FSM states: IDLE, PEND, ACK.
  - IDLE: on dbg_req_i=1, latch dbg_we_i/dbg_addr_i/dbg_wdata_i and go to PEND. Later changes to the debug inputs are ignored until the next IDLE.
  - PEND, reg_wen_i=0 (commit):
    - Write: drive the latched write as the effective write.
    - Read: register the array (or 0 for x0) into dbg_rdata_o.
    - Clear the wait counter, drop stall_o, and go to ACK.
  - PEND, reg_wen_i=1: the core wins. Increment the wait counter (saturating). When the counter reaches STARVE_LIMIT, set stall_o=1 (registered). stall_o stays high until the commit cycle; ctrl must then deassert reg_wen_i.
  - ACK: dbg_ack_o=1. Stay while dbg_req_i=1; go to IDLE when dbg_req_i=0, with dbg_ack_o dropping on that edge. dbg_rdata_o holds its value until the next read commit.
- Latency:
  - Best-case debug ack: 2 cycles after req (IDLE->PEND->ACK).
  - Debug write visibility: on the read ports in the commit cycle (bypass); in the array from the next cycle.
- Simultaneous events:
  - Core write and a debug access to the same address in the same cycle are impossible by construction, because debug commits only when reg_wen_i=0.
  - A debug read commit observes the array value before that edge.
- Reset mid-handshake: returns to IDLE with ack 0. The requester must deassert and re-raise req.

Optional Feature:
REGS_DEBUG_PORT_EN
- Defined: the debug FSM, wait counter, stall logic and debug write path are built as described.
- Undefined: debug inputs are ignored; dbg_ack_o, dbg_rdata_o and stall_o are tied to 0; the effective write is the core write only. The port list is unchanged.

Decomposition:
- defines.v gets: ZERO_REG (5'd0), REG_NUM (32), REG_ADDR_W (5), ZERO_WORD (32'h0).
- FSM state encodings are local parameters.
- One natural sub-module: regs_dbg_ctrl, containing the FSM, wait counter, stall_o and the latched request. It outputs the debug write strobe/addr/data and the read-capture enable.
- The array and bypass stay in regs.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 0. Write x0=32'hDEADBEEF -> x0 still reads 0 on both ports.
- Core writes x5=32'h12345678 with rs1_addr_i=5 in the same cycle -> rs1_data_o=32'h12345678 that cycle (bypass). Same value on the following cycle from the array.
- reg_wen_i=0, debug write x7=32'hA5A5A5A5 -> dbg_ack_o high 2 cycles after req. Core read of x7 returns 32'hA5A5A5A5. Deassert req -> ack low next cycle.
- Debug read x5 with reg_wen_i held 1, STARVE_LIMIT=4 -> stall_o rises after 4 waiting cycles. Drop reg_wen_i -> ack next cycle, dbg_rdata_o=32'h12345678, stall_o=0.
- Assert rst_n=0 while FSM is in PEND with stall_o=1 -> stall_o, dbg_ack_o and the registers read 0 immediately. The debug write never lands.
- Build without REGS_DEBUG_PORT_EN, toggle dbg_req_i with dbg_we_i=1 -> dbg_ack_o and stall_o stay 0 and the target register is unchanged.
